// File: rtl/rx_header_sequencer_ble_if.sv
// Signal bundle between the BLE receive sequencer, the header/payload chains and the link
// controller. The master side drives the control and strobe inputs; the sequencer is the slave.
interface rx_header_sequencer_ble_if;
   logic       rx_enable;
   logic [2:0] my_lt_addr;
   logic       sync_found;
   logic       hdr_valid;
   logic       hdr_bit;
   logic       hdr_done;
   logic       hdr_err;
   logic       payload_done;
   logic       hdr_chain_en;
   logic       payload_chain_en;
   logic [2:0] lt_addr;
   logic [3:0] pkt_type;
   logic       flow;
   logic       arqn;
   logic       seqn;
   logic       pkt_ok;
   logic       pkt_fail;
   logic [1:0] status;

   modport master (
      output rx_enable, my_lt_addr, sync_found, hdr_valid, hdr_bit, hdr_done, hdr_err,
             payload_done,
      input  hdr_chain_en, payload_chain_en, lt_addr, pkt_type, flow, arqn, seqn, pkt_ok,
             pkt_fail, status
   );

   modport slave (
      input  rx_enable, my_lt_addr, sync_found, hdr_valid, hdr_bit, hdr_done, hdr_err,
             payload_done,
      output hdr_chain_en, payload_chain_en, lt_addr, pkt_type, flow, arqn, seqn, pkt_ok,
             pkt_fail, status
   );
endinterface

// File: rtl/rx_header_sequencer_ble.sv
// BLE/BT receive sequencer: enables the header chain after sync, collects and checks the
// header, hands over to the payload chain and reports per-packet status.
module rx_header_sequencer_ble #(
   parameter int unsigned HDR_BITS     = 10,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned HDR_TIMEOUT  = 200,
   parameter int unsigned PAY_TIMEOUT  = 3000,
   parameter bit          ACCEPT_BCAST = 1'b1
) (
   input logic                      clk,
   input logic                      reset,
   rx_header_sequencer_ble_if.slave bus
);

   localparam int unsigned          BitCntW    = $clog2(HDR_BITS + 2);
   localparam logic [BitCntW-1:0]   BitsFull   = BitCntW'(HDR_BITS);
   localparam logic [BitCntW-1:0]   BitsSat    = BitCntW'(HDR_BITS + 1);
   localparam logic [CNT_W-1:0]     HdrTmoLast = CNT_W'(HDR_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]     PayTmoLast = CNT_W'(PAY_TIMEOUT - 1);
   localparam logic [1:0]           StatOk     = 2'd0;
   localparam logic [1:0]           StatFmt    = 2'd1;
   localparam logic [1:0]           StatAddr   = 2'd2;
   localparam logic [1:0]           StatTmo    = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StWaitSync,
      StHdr,
      StCheck,
      StPayload,
      StDone,
      StFail
   } state_e;

   state_e               state_q;
   logic [HDR_BITS-1:0]  shreg_q;
   logic [BitCntW-1:0]   bit_cnt_q;
   logic [CNT_W-1:0]     timer_q;
   logic                 err_q;
   logic [1:0]           code_q;
   logic                 hdr_chain_en_q;
   logic                 payload_chain_en_q;
   logic [2:0]           lt_addr_q;
   logic [3:0]           pkt_type_q;
   logic                 flow_q;
   logic                 arqn_q;
   logic                 seqn_q;
   logic                 pkt_ok_q;
   logic                 pkt_fail_q;
   logic [1:0]           status_q;

   // Header is LSB first, so after HDR_BITS shifts the first bit sits in shreg_q[0].
   logic [2:0] hdr_lt;
   logic [3:0] hdr_type;
   logic       addr_ok;
   assign hdr_lt   = shreg_q[2:0];
   assign hdr_type = shreg_q[6:3];
   assign addr_ok  = (hdr_lt == bus.my_lt_addr) || (ACCEPT_BCAST && (hdr_lt == 3'd0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q            <= StIdle;
         shreg_q            <= '0;
         bit_cnt_q          <= '0;
         timer_q            <= '0;
         err_q              <= 1'b0;
         code_q             <= StatOk;
         hdr_chain_en_q     <= 1'b0;
         payload_chain_en_q <= 1'b0;
         lt_addr_q          <= '0;
         pkt_type_q         <= '0;
         flow_q             <= 1'b0;
         arqn_q             <= 1'b0;
         seqn_q             <= 1'b0;
         pkt_ok_q           <= 1'b0;
         pkt_fail_q         <= 1'b0;
         status_q           <= StatOk;
      end else begin
         pkt_ok_q   <= 1'b0;
         pkt_fail_q <= 1'b0;
         if (!bus.rx_enable) begin
            state_q            <= StIdle;
            hdr_chain_en_q     <= 1'b0;
            payload_chain_en_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: state_q <= StWaitSync;
               StWaitSync: begin
                  if (bus.sync_found) begin
                     state_q        <= StHdr;
                     hdr_chain_en_q <= 1'b1;
                     bit_cnt_q      <= '0;
                     timer_q        <= '0;
                     shreg_q        <= '0;
                  end
               end
               StHdr: begin
                  // Count one past HDR_BITS so over-long headers are flagged in CHECK.
                  if (bus.hdr_valid && (bit_cnt_q != BitsSat)) begin
                     if (bit_cnt_q != BitsFull) begin
                        shreg_q <= {bus.hdr_bit, shreg_q[HDR_BITS-1:1]};
                     end
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                  if (bus.hdr_done) begin
                     err_q          <= bus.hdr_err;
                     hdr_chain_en_q <= 1'b0;
                     state_q        <= StCheck;
                  end else if (timer_q == HdrTmoLast) begin
                     hdr_chain_en_q <= 1'b0;
                     code_q         <= StatTmo;
                     state_q        <= StFail;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               StCheck: begin
                  lt_addr_q  <= hdr_lt;
                  pkt_type_q <= hdr_type;
                  flow_q     <= shreg_q[7];
                  arqn_q     <= shreg_q[8];
                  seqn_q     <= shreg_q[9];
                  if (err_q || (bit_cnt_q != BitsFull)) begin
                     code_q  <= StatFmt;
                     state_q <= StFail;
                  end else if (!addr_ok) begin
                     code_q  <= StatAddr;
                     state_q <= StFail;
                  end else if (hdr_type[3:1] == 3'b000) begin
                     // NULL and POLL carry no payload.
                     state_q <= StDone;
                  end else begin
                     timer_q            <= '0;
                     payload_chain_en_q <= 1'b1;
                     state_q            <= StPayload;
                  end
               end
               StPayload: begin
                  if (bus.payload_done) begin
                     payload_chain_en_q <= 1'b0;
                     state_q            <= StDone;
                  end else if (timer_q == PayTmoLast) begin
                     payload_chain_en_q <= 1'b0;
                     code_q             <= StatTmo;
                     state_q            <= StFail;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               StDone: begin
                  pkt_ok_q <= 1'b1;
                  status_q <= StatOk;
                  state_q  <= StWaitSync;
               end
               StFail: begin
                  pkt_fail_q <= 1'b1;
                  status_q   <= code_q;
                  state_q    <= StWaitSync;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.hdr_chain_en     = hdr_chain_en_q;
   assign bus.payload_chain_en = payload_chain_en_q;
   assign bus.lt_addr          = lt_addr_q;
   assign bus.pkt_type         = pkt_type_q;
   assign bus.flow             = flow_q;
   assign bus.arqn             = arqn_q;
   assign bus.seqn             = seqn_q;
   assign bus.pkt_ok           = pkt_ok_q;
   assign bus.pkt_fail         = pkt_fail_q;
   assign bus.status           = status_q;

endmodule

// File: tb/tb_rx_header_sequencer_ble.sv
// Directed bench for rx_header_sequencer_ble: header capture, filtering, payload handover,
// timeouts, rx_enable drop and asynchronous reset.
module tb_rx_header_sequencer_ble;

   localparam int unsigned HdrTimeout = 200;
   localparam int unsigned PayTimeout = 3000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   rx_header_sequencer_ble_if bus ();

   rx_header_sequencer_ble #(
      .HDR_BITS    (10),
      .CNT_W       (16),
      .HDR_TIMEOUT (HdrTimeout),
      .PAY_TIMEOUT (PayTimeout),
      .ACCEPT_BCAST(1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int ok_cnt, fail_cnt, hce_cnt, pce_cnt;
   int both_total = 0;
   int n;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (bus.pkt_ok) ok_cnt++;
      if (bus.pkt_fail) fail_cnt++;
      if (bus.pkt_ok && bus.pkt_fail) both_total++;
      if (bus.hdr_chain_en) hce_cnt++;
      if (bus.payload_chain_en) pce_cnt++;
   endtask

   task automatic clear_cnts();
      ok_cnt   = 0;
      fail_cnt = 0;
      hce_cnt  = 0;
      pce_cnt  = 0;
   endtask

   // Sync, deliver nbits of {s,a,f,typ,lt} LSB first, then hdr_done. Ends in CHECK.
   task automatic hdr_phase(input logic [2:0] lt, input logic [3:0] typ, input logic f,
                            input logic a, input logic s, input int nbits, input logic err);
      logic [10:0] w;
      w = {1'b0, s, a, f, typ, lt};
      bus.sync_found = 1'b1;
      step();
      bus.sync_found = 1'b0;
      check_eq("hce_after_sync", bus.hdr_chain_en, 1);
      for (int i = 0; i < nbits; i++) begin
         bus.hdr_valid = 1'b1;
         bus.hdr_bit   = w[i];
         step();
      end
      bus.hdr_valid = 1'b0;
      bus.hdr_bit   = 1'b0;
      bus.hdr_done  = 1'b1;
      bus.hdr_err   = err;
      step();
      bus.hdr_done  = 1'b0;
      bus.hdr_err   = 1'b0;
      check_eq("hce_in_check", bus.hdr_chain_en, 0);
   endtask

   // From CHECK: one cycle to DONE/FAIL, one more for the registered pulse.
   task automatic expect_pulse(input string tag, input logic ok, input logic [1:0] code);
      step();
      step();
      check_eq({tag, "_ok"}, bus.pkt_ok, ok);
      check_eq({tag, "_fail"}, bus.pkt_fail, !ok);
      check_eq({tag, "_status"}, bus.status, code);
      step();
      check_eq({tag, "_one_cycle"}, bus.pkt_ok | bus.pkt_fail, 0);
   endtask

   task automatic wait_pulse(input int bound, output int cnt);
      cnt = 0;
      while (!(bus.pkt_ok || bus.pkt_fail) && cnt < bound) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      bus.rx_enable    = 1'b0;
      bus.my_lt_addr   = 3'd5;
      bus.sync_found   = 1'b0;
      bus.hdr_valid    = 1'b0;
      bus.hdr_bit      = 1'b0;
      bus.hdr_done     = 1'b0;
      bus.hdr_err      = 1'b0;
      bus.payload_done = 1'b0;
      clear_cnts();

      #12;
      check_eq("rst_hce", bus.hdr_chain_en, 0);
      check_eq("rst_pce", bus.payload_chain_en, 0);
      check_eq("rst_pulses", {bus.pkt_ok, bus.pkt_fail}, 0);
      check_eq("rst_status", bus.status, 0);
      check_eq("rst_fields", {bus.lt_addr, bus.pkt_type, bus.flow, bus.arqn, bus.seqn}, 0);
      reset = 1'b1;
      bus.rx_enable = 1'b1;
      step();

      // NULL packet to own address.
      clear_cnts();
      hdr_phase(3'd5, 4'b0000, 1'b1, 1'b0, 1'b1, 10, 1'b0);
      expect_pulse("null", 1'b1, 2'd0);
      check_eq("null_lt", bus.lt_addr, 5);
      check_eq("null_type", bus.pkt_type, 0);
      check_eq("null_fas", {bus.flow, bus.arqn, bus.seqn}, 3'b101);
      check_eq("null_pce_never", pce_cnt, 0);

      // Payload packet, payload_done in the 50th PAYLOAD cycle.
      clear_cnts();
      hdr_phase(3'd5, 4'b0100, 1'b0, 1'b1, 1'b0, 10, 1'b0);
      step();
      check_eq("pay_pce_on", bus.payload_chain_en, 1);
      repeat (49) step();
      bus.payload_done = 1'b1;
      step();
      bus.payload_done = 1'b0;
      check_eq("pay_pce_off", bus.payload_chain_en, 0);
      check_eq("pay_pce_len", pce_cnt, 50);
      step();
      check_eq("pay_ok", bus.pkt_ok, 1);
      check_eq("pay_status", bus.status, 0);
      check_eq("pay_type", bus.pkt_type, 4);
      check_eq("pay_fas", {bus.flow, bus.arqn, bus.seqn}, 3'b010);
      step();

      // Format and address failures, broadcast acceptance.
      hdr_phase(3'd5, 4'b0000, 1'b0, 1'b0, 1'b0, 10, 1'b1);
      expect_pulse("hec", 1'b0, 2'd1);
      hdr_phase(3'd5, 4'b0000, 1'b0, 1'b0, 1'b0, 9, 1'b0);
      expect_pulse("short", 1'b0, 2'd1);
      hdr_phase(3'd5, 4'b0000, 1'b0, 1'b0, 1'b0, 11, 1'b0);
      expect_pulse("long", 1'b0, 2'd1);
      hdr_phase(3'd3, 4'b0000, 1'b0, 1'b0, 1'b0, 10, 1'b0);
      expect_pulse("addr", 1'b0, 2'd2);
      check_eq("addr_lt", bus.lt_addr, 3);
      hdr_phase(3'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 10, 1'b0);
      expect_pulse("bcast", 1'b1, 2'd0);
      check_eq("bcast_type", bus.pkt_type, 1);

      // Header timeout: chain enabled HdrTimeout cycles, pulse one cycle after FAIL.
      clear_cnts();
      bus.sync_found = 1'b1;
      step();
      bus.sync_found = 1'b0;
      wait_pulse(2 * HdrTimeout, n);
      check_eq("htmo_latency", n, HdrTimeout + 1);
      check_eq("htmo_fail", bus.pkt_fail, 1);
      check_eq("htmo_status", bus.status, 3);
      check_eq("htmo_hce_off", bus.hdr_chain_en, 0);
      check_eq("htmo_hce_len", hce_cnt, HdrTimeout);
      step();

      // Payload timeout.
      clear_cnts();
      hdr_phase(3'd5, 4'b0010, 1'b0, 1'b0, 1'b0, 10, 1'b0);
      step();
      wait_pulse(2 * PayTimeout, n);
      check_eq("ptmo_latency", n, PayTimeout + 1);
      check_eq("ptmo_fail", bus.pkt_fail, 1);
      check_eq("ptmo_status", bus.status, 3);
      check_eq("ptmo_pce_len", pce_cnt, PayTimeout);
      step();

      // rx_enable dropped mid-header.
      clear_cnts();
      bus.sync_found = 1'b1;
      step();
      bus.sync_found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.hdr_valid = 1'b1;
         bus.hdr_bit   = 1'b1;
         step();
      end
      bus.hdr_valid = 1'b0;
      bus.rx_enable = 1'b0;
      step();
      check_eq("drop_hdr_hce", bus.hdr_chain_en, 0);
      repeat (5) step();
      check_eq("drop_hdr_nopulse", ok_cnt + fail_cnt, 0);
      bus.rx_enable = 1'b1;
      step();
      hdr_phase(3'd5, 4'b0000, 1'b0, 1'b0, 1'b1, 10, 1'b0);
      expect_pulse("rearm1", 1'b1, 2'd0);

      // rx_enable dropped mid-payload.
      clear_cnts();
      hdr_phase(3'd5, 4'b0100, 1'b0, 1'b0, 1'b0, 10, 1'b0);
      repeat (11) step();
      bus.rx_enable = 1'b0;
      step();
      check_eq("drop_pay_pce", bus.payload_chain_en, 0);
      repeat (5) step();
      check_eq("drop_pay_nopulse", ok_cnt + fail_cnt, 0);
      bus.rx_enable = 1'b1;
      step();
      hdr_phase(3'd5, 4'b0001, 1'b0, 1'b0, 1'b0, 10, 1'b0);
      expect_pulse("rearm2", 1'b1, 2'd0);

      // payload_done in the same cycle the payload timer expires.
      hdr_phase(3'd5, 4'b0100, 1'b1, 1'b1, 1'b1, 10, 1'b0);
      step();
      repeat (PayTimeout - 1) step();
      bus.payload_done = 1'b1;
      step();
      bus.payload_done = 1'b0;
      step();
      check_eq("race_ok", bus.pkt_ok, 1);
      check_eq("race_fail", bus.pkt_fail, 0);
      check_eq("race_status", bus.status, 0);
      step();

      // Asynchronous reset mid-payload clears outputs before the next edge.
      hdr_phase(3'd5, 4'b0100, 1'b1, 1'b0, 1'b0, 10, 1'b0);
      repeat (6) step();
      #2 reset = 1'b0;
      #1;
      check_eq("arst_en", {bus.hdr_chain_en, bus.payload_chain_en}, 0);
      check_eq("arst_pulses", {bus.pkt_ok, bus.pkt_fail}, 0);
      check_eq("arst_fields", {bus.lt_addr, bus.pkt_type, bus.flow, bus.arqn, bus.seqn}, 0);
      check_eq("arst_status", bus.status, 0);
      #1 reset = 1'b1;

      check_eq("never_both", both_total, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
